// File: rtl/toggle_handshake_rx_if.sv
// Signals of the two-phase toggle handshake (transmitter side) and the valid/ready
// side toward the local consumer. The receiver uses slave; a driver or bench uses master.
interface toggle_handshake_rx_if #(
  parameter int WIDTH = 4
);
  logic             req_tog;
  logic [WIDTH-1:0] data_in;
  logic             ack_tog;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output req_tog, data_in, out_ready,
    input  ack_tog, out_data, out_valid
  );

  modport slave (
    input  req_tog, data_in, out_ready,
    output ack_tog, out_data, out_valid
  );
endinterface

// File: rtl/toggle_handshake_rx.sv
// Receive end of the two-phase toggle handshake: synchronizes req_tog, captures data_in
// onto a valid/ready port and returns ack_tog. Optional parity check: TOGRX_PARITY_EN.
//
// state | meaning
// IDLE  | no word pending, waiting for a detected req_tog flip
// VALID | word presented on out_data, waiting for out_ready
module toggle_handshake_rx #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  toggle_handshake_rx_if.slave hs,
  input  logic                 cnt_clr,
  output logic                 overrun,
  output logic [COUNT_W-1:0]   xfer_cnt
`ifdef TOGRX_PARITY_EN
  ,
  input  logic                 par_in,
  output logic                 par_err
`endif
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] VALID = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   flip;
  logic [0:0]             state_q;
  logic                   capture;
  logic                   accept;
  logic [WIDTH-1:0]       data_q;
  logic                   valid_q;
  logic                   ack_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], hs.req_tog};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // History always follows the synchronizer, so a flip seen in VALID is consumed here
  // and never delivered later.
  assign flip    = sync_q[SYNC_STAGES-1] ^ hist_q;
  assign capture = (state_q == IDLE) && flip;
  assign accept  = (state_q == VALID) && hs.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture) begin
            data_q  <= hs.data_in;
            valid_q <= 1'b1;
            state_q <= VALID;
          end
        end
        default: begin
          if (accept) begin
            valid_q <= 1'b0;
            ack_q   <= ~ack_q;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_cnt <= '0;
      overrun  <= 1'b0;
    end else if (cnt_clr) begin
      xfer_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      if (accept && (xfer_cnt != {COUNT_W{1'b1}}))
        xfer_cnt <= xfer_cnt + COUNT_W'(1);
      if ((state_q == VALID) && flip)
        overrun <= 1'b1;
    end
  end

`ifdef TOGRX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      par_err <= 1'b0;
    else if (cnt_clr)
      par_err <= 1'b0;
    else if (capture && (^{hs.data_in, par_in}))
      par_err <= 1'b1;
  end
`endif

  assign hs.out_data  = data_q;
  assign hs.out_valid = valid_q;
  assign hs.ack_tog   = ack_q;

endmodule

// File: doc/toggle_handshake_rx.md
Name: toggle_handshake_rx

Overview:
Receiving end of the team's two-phase toggle handshake. The transmitter builds its request with a toggle flip-flop: each new word flips req_tog while data_in is held stable. This block does the following:
- synchronizes req_tog and detects each flip;
- captures data_in and presents it on a valid/ready interface to the local consumer;
- returns an acknowledge toggle (ack_tog) once the word is taken.

It sits at the clock-domain boundary between the transmitter logic and the local datapath.

Parameters:
WIDTH, 4, data bus width in bits (1..32)
SYNC_STAGES, 2, synchronizer depth on req_tog (2..4)
COUNT_W, 8, width of saturating transfer counter

Ports:
clk  input  1  single clock, rising-edge
reset  input  1  asynchronous, active-high reset
req_tog  input  1  request toggle from transmitter (asynchronous to clk)
data_in  input  WIDTH  transmitter data, stable from req_tog flip until ack_tog flip
out_data  output  WIDTH  captured word
out_valid  output  1  captured word pending
out_ready  input  1  consumer accepts word
ack_tog  output  1  acknowledge toggle back to transmitter
overrun  output  1  sticky: req_tog flipped while a word was pending
xfer_cnt  output  COUNT_W  saturating count of completed transfers
cnt_clr  input  1  synchronous clear of xfer_cnt and overrun

Behaviour:
- Reset values:
  - sync chain, edge-detect history reg, out_data, out_valid, ack_tog, overrun and xfer_cnt are all 0.
  - FSM goes to IDLE.
- Asynchronous reset must act immediately, without waiting for clk.
- Synchronizer and edge detect:
  - req_tog passes through SYNC_STAGES flops, then one history flop.
  - A flip is detected when the last sync stage differs from the history flop. This is registered edge logic, so there is no glitch path from req_tog.
- FSM states are IDLE and VALID.
  - IDLE: on a detected flip, latch data_in into out_data, set out_valid=1, go to VALID.
  - VALID: when out_ready=1, set out_valid=0, invert ack_tog, increment xfer_cnt (saturate at all-ones), and return to IDLE.
  - VALID with out_ready=0: hold out_data and out_valid stable.
- Latency:
  - A req_tog change before clk edge 1 gives out_valid=1 after edge SYNC_STAGES+1 (default: after edge 3).
  - ack_tog flips on the same edge that out_valid falls.
- Back-to-back transfers: a flip detected in the first IDLE cycle after a transfer is accepted. There is no extra bubble beyond one IDLE cycle.
- Protocol violation: a flip detected while in VALID sets overrun=1 (sticky).
  - The new flip is discarded and is never later acked.
  - out_data is not overwritten.
- Simultaneous flip and out_ready in VALID:
  - The transfer completes normally.
  - The flip is treated as an overrun and discarded.
- cnt_clr=1 clears xfer_cnt and overrun on the next edge.
  - If an increment occurs in the same cycle, cnt_clr wins and xfer_cnt=0.
  - If an overrun occurs in the same cycle, overrun=0 as well.
- Reset mid-operation:
  - Any pending word is dropped and ack_tog returns to 0.
  - The transmitter must share the reset so that its toggle phase realigns.
- Data capture uses data_in as it is when the flip is detected. No synchronizer is applied to data_in; its stability is guaranteed by the protocol.

Optional Feature:
TOGRX_PARITY_EN
- Defined:
  - Adds input par_in (1 bit, even parity over data_in) and output par_err (1 bit, sticky).
  - On capture, par_err is set if the XOR of data_in and par_in equals 1.
  - The word is still delivered.
  - par_err resets to 0 and is cleared by cnt_clr.
- Not defined: par_in and par_err do not exist and there is no parity logic.

Test Plan:
1. Single transfer: after reset, data_in=4'hA, flip req_tog 0->1, out_ready=1 → out_valid=1 after edge 3 with out_data=4'hA. Next edge: out_valid=0, ack_tog=1, xfer_cnt=1.
2. Backpressure: out_ready=0 for 10 cycles after valid → out_data and out_valid held stable and ack_tog unchanged. Raise out_ready → one transfer, ack_tog flips once.
3. Overrun: flip req_tog twice with out_ready=0 → overrun=1, out_data keeps the first word, xfer_cnt +1 only after ready. Then cnt_clr=1 → overrun=0, xfer_cnt=0.
4. Saturation and clear: COUNT_W=2, 5 transfers → xfer_cnt=3. cnt_clr asserted in the same cycle as a transfer → xfer_cnt=0.
5. Reset mid-operation: assert reset while out_valid=1 → out_valid, ack_tog and out_data go to 0 immediately, without waiting for clk. After release, the next flip is delivered normally.
6. With TOGRX_PARITY_EN: data_in=4'b0111 with par_in=0 → par_err=1 and the word is still delivered. data_in=4'b0011 with par_in=0 → par_err stays 0 when starting from a cleared state.
